ir_detect_filter: RTL and testbench

IR_DETECT_FILTER -- requirements
Module: ir_detect_filter

---
 rtl/ir_detect_filter_if.sv | 30 +++
 rtl/ir_detect_filter.sv | 142 ++++++++++++++
 tb/tb_ir_detect_filter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ir_detect_filter_if.sv
// Signal bundle between the IR detect filter and its user: raw sensor in,
// counter clear in, and the qualified level, strobes and event count out.
interface ir_detect_filter_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   ir_raw;
    logic                   cnt_clr;
    logic                   ir_out;
    logic                   det_pulse;
    logic                   rel_pulse;
    logic [COUNT_WIDTH-1:0] det_count;

    modport master (
        output ir_raw,
        output cnt_clr,
        input  ir_out,
        input  det_pulse,
        input  rel_pulse,
        input  det_count
    );

    modport slave (
        input  ir_raw,
        input  cnt_clr,
        output ir_out,
        output det_pulse,
        output rel_pulse,
        output det_count
    );
endinterface

// File: rtl/ir_detect_filter.sv
// Debounces an asynchronous IR presence sensor into a clean level with
// arrival/departure strobes, an optional minimum hold and a saturating count.
module ir_detect_filter #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 0,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               rst,
    ir_detect_filter_if.slave  bus
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL_ON  = 2'd1,
        ACTIVE   = 2'd2,
        QUAL_OFF = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [HOLD_W-1:0]      hold;
    logic [HOLD_W-1:0]      hold_next;
    logic                   sync1;
    logic                   ir_s;
    logic                   ir_out_q;
    logic                   ir_out_next;
    logic                   det_q;
    logic                   det_next;
    logic                   rel_q;
    logic                   rel_next;
    logic [COUNT_WIDTH-1:0] det_count_q;
    logic                   hold_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            ir_s  <= 1'b0;
        end else begin
            sync1 <= bus.ir_raw;
            ir_s  <= sync1;
        end
    end

    // hold counts ACTIVE cycles including the current one, saturating at HOLD_CYCLES
    assign hold_done = int'(hold) >= HOLD_CYCLES;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hold_next  = hold;
        det_next   = 1'b0;
        rel_next   = 1'b0;
        case (state)
            IDLE: begin
                if (ir_s) begin
                    state_next = QUAL_ON;
                    cnt_next   = CNT_W'(1);
                end
            end
            QUAL_ON: begin
                if (!ir_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ACTIVE;
                    cnt_next   = '0;
                    hold_next  = HOLD_W'(1);
                    det_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (int'(hold) < HOLD_CYCLES) begin
                    hold_next = hold + HOLD_W'(1);
                end
                if (!ir_s && hold_done) begin
                    state_next = QUAL_OFF;
                    cnt_next   = CNT_W'(1);
                end
            end
            QUAL_OFF: begin
                if (ir_s) begin
                    state_next = ACTIVE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    rel_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        ir_out_next = (state_next == ACTIVE) || (state_next == QUAL_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hold     <= '0;
            ir_out_q <= 1'b0;
            det_q    <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            hold     <= hold_next;
            ir_out_q <= ir_out_next;
            det_q    <= det_next;
            rel_q    <= rel_next;
        end
    end

    // The count follows the visible strobe, so a clear in the strobe cycle still counts it
    always_ff @(posedge clk) begin
        if (rst) begin
            det_count_q <= '0;
        end else if (bus.cnt_clr) begin
            det_count_q <= det_q ? COUNT_WIDTH'(1) : '0;
        end else if (det_q && (det_count_q != COUNT_MAX)) begin
            det_count_q <= det_count_q + COUNT_WIDTH'(1);
        end
    end

    assign bus.ir_out    = ir_out_q;
    assign bus.det_pulse = det_q;
    assign bus.rel_pulse = rel_q;
    assign bus.det_count = det_count_q;
endmodule

// File: tb/tb_ir_detect_filter.sv
// Self-checking bench: segment table with a run-length reference model and a
// pulse scoreboard, plus hand sequences for clear, reset and hold behaviour.
module tb_ir_detect_filter;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_detect_filter_if #(.COUNT_WIDTH(CW)) bus_a ();
    ir_detect_filter_if #(.COUNT_WIDTH(CW)) bus_b ();

    ir_detect_filter #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(0), .COUNT_WIDTH(CW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ir_detect_filter #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(10), .COUNT_WIDTH(CW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int kind;
        int cyc;
    } event_t;

    event_t exp_a[$];
    event_t exp_b[$];

    typedef struct {
        logic level;
        int   len;
        logic exp_ir_out;
        int   exp_count;
    } vec_t;

    vec_t vecs[$];

    logic model_level = 1'b0;
    int   model_count = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic monitor_pulses(input int which, input logic det, input logic rel);
        event_t e;
        int kind;
        if (det && rel) begin
            checks++;
            errors++;
            $display("[TB] FAIL overlap dut%0d at cycle %0d: got det=1 rel=1 expected at most one", which, cyc);
        end
        if (det || rel) begin
            kind = det ? 0 : 1;
            if ((which == 0 && exp_a.size() == 0) || (which == 1 && exp_b.size() == 0)) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse dut%0d at cycle %0d: got kind %0d expected none", which, cyc, kind);
            end else begin
                e = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check_output("pulse_kind", kind, e.kind);
                check_output("pulse_cycle", cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_pulses(0, bus_a.det_pulse, bus_a.rel_pulse);
        monitor_pulses(1, bus_b.det_pulse, bus_b.rel_pulse);
    end

    // A level held for at least D samples against the qualified level flips it D+2 edges after it starts
    task automatic apply_stimulus(input logic level, input int len);
        event_t e;
        bus_a.ir_raw = level;
        if (level != model_level && len >= D) begin
            e.kind = level ? 0 : 1;
            e.cyc  = cyc + D + 2;
            exp_a.push_back(e);
            model_level = level;
            if (level && model_count < CMAX) model_count++;
        end
        repeat (len) @(negedge clk);
    endtask

    initial begin
        event_t e;
        int n;

        rst           = 1'b1;
        bus_a.ir_raw  = 1'b0;
        bus_a.cnt_clr = 1'b0;
        bus_b.ir_raw  = 1'b0;
        bus_b.cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_ir_out", bus_a.ir_out, 0);
        check_output("reset_det", bus_a.det_pulse, 0);
        check_output("reset_rel", bus_a.rel_pulse, 0);
        check_output("reset_count", bus_a.det_count, 0);
        check_output("reset_count_b", bus_b.det_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs.push_back('{1'b1, 8, 1'b1, 1});
        vecs.push_back('{1'b0, 2, 1'b1, 1});
        vecs.push_back('{1'b1, 6, 1'b1, 1});
        vecs.push_back('{1'b0, 8, 1'b0, 1});
        vecs.push_back('{1'b1, 3, 1'b0, 1});
        vecs.push_back('{1'b0, 6, 1'b0, 1});
        vecs.push_back('{1'b1, 1, 1'b0, 1});
        vecs.push_back('{1'b0, 5, 1'b0, 1});
        for (int k = 2; k <= 17; k++) begin
            vecs.push_back('{1'b1, 8, 1'b1, (k > CMAX) ? CMAX : k});
            vecs.push_back('{1'b0, 8, 1'b0, (k > CMAX) ? CMAX : k});
        end

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].level, vecs[i].len);
            check_output($sformatf("vec%0d_ir_out", i), bus_a.ir_out, vecs[i].exp_ir_out);
            check_output($sformatf("vec%0d_count", i), bus_a.det_count, vecs[i].exp_count);
            check_output($sformatf("vec%0d_model_count", i), bus_a.det_count, model_count);
        end

        // Clear in the same cycle as an arrival strobe leaves a count of one
        n = cyc;
        bus_a.ir_raw = 1'b1;
        e.kind = 0;
        e.cyc  = n + D + 2;
        exp_a.push_back(e);
        repeat (D + 2) @(negedge clk);
        check_output("clr_det_visible", bus_a.det_pulse, 1);
        bus_a.cnt_clr = 1'b1;
        @(negedge clk);
        bus_a.cnt_clr = 1'b0;
        check_output("clr_with_det_count", bus_a.det_count, 1);
        repeat (2) @(negedge clk);
        bus_a.cnt_clr = 1'b1;
        @(negedge clk);
        bus_a.cnt_clr = 1'b0;
        check_output("clr_alone_count", bus_a.det_count, 0);
        check_output("clr_alone_ir_out", bus_a.ir_out, 1);

        // Reset while qualifying the release: no strobe, everything cleared
        bus_a.ir_raw = 1'b0;
        repeat (4) @(negedge clk);
        check_output("qual_off_ir_out", bus_a.ir_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_qoff_ir_out", bus_a.ir_out, 0);
        check_output("rst_qoff_det", bus_a.det_pulse, 0);
        check_output("rst_qoff_rel", bus_a.rel_pulse, 0);
        check_output("rst_qoff_count", bus_a.det_count, 0);
        repeat (8) @(negedge clk);
        check_output("rst_qoff_settled_ir_out", bus_a.ir_out, 0);

        // Input already high when reset releases is qualified from scratch
        n = cyc;
        rst = 1'b1;
        bus_a.ir_raw = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e.kind = 0;
        e.cyc  = n + D + 3;
        exp_a.push_back(e);
        repeat (D + 1) @(negedge clk);
        check_output("post_rst_not_yet", bus_a.ir_out, 0);
        repeat (3) @(negedge clk);
        check_output("post_rst_ir_out", bus_a.ir_out, 1);
        check_output("post_rst_count", bus_a.det_count, 1);

        // Hold of 10 cycles delays release qualification after an early drop
        n = cyc;
        bus_b.ir_raw = 1'b1;
        e.kind = 0;
        e.cyc  = n + D + 2;
        exp_b.push_back(e);
        repeat (D + 4) @(negedge clk);
        check_output("hold_rise_ir_out", bus_b.ir_out, 1);
        bus_b.ir_raw = 1'b0;
        e.kind = 1;
        e.cyc  = n + D + 2 + 10 + D - 1;
        exp_b.push_back(e);
        repeat (10) @(negedge clk);
        check_output("hold_still_high", bus_b.ir_out, 1);
        @(negedge clk);
        check_output("hold_released", bus_b.ir_out, 0);
        check_output("hold_rel_pulse", bus_b.rel_pulse, 1);
        repeat (6) @(negedge clk);
        check_output("hold_count", bus_b.det_count, 1);

        check_output("pending_a", exp_a.size(), 0);
        check_output("pending_b", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
